fei4_rx_merger: RTL
===================

Name: fei4_rx_merger

Overview:
- Downstream consumer of up to CHANNELS fei4_rx receiver FIFOs (the FIFO_READ/FIFO_EMPTY/FIFO_DATA side); merges them into one 32-bit ready/valid stream toward the SRAM FIFO / readout path.
- Round-robin arbitration with bounded burst length per grant; per-channel enable and saturating per-channel word counters for monitoring.
- Single clock domain (fei4_rx FIFO_CLK side, i.e. BUS_CLK).

Parameters:
CHANNELS, 4, number of fei4_rx inputs (1..8)
BURST_MAX, 16, max consecutive words taken from one channel per grant (1..255)
CNT_WIDTH, 16, width of each per-channel word counter

Ports:
BUS_CLK  in  1  clock
BUS_RST_N  in  1  reset: synchronous, active-low
RX_FIFO_EMPTY  in  CHANNELS  per-channel empty flag of fei4_rx FIFO
RX_FIFO_DATA  in  32*CHANNELS  per-channel first-word-fall-through data; channel g at [32g+31:32g]
RX_FIFO_READ  out  CHANNELS  per-channel pop strobe, one-hot or zero
CH_ENABLE  in  CHANNELS  channel participates in arbitration when 1
CNT_CLEAR  in  1  clears all word counters
OUT_DATA  out  32  merged data word, passed through unmodified
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  sink accepts word when OUT_VALID & OUT_READY
WORD_CNT  out  CNT_WIDTH*CHANNELS  words forwarded per channel, saturating
BUSY  out  1  high while in STREAM state

Behaviour:
- Reset (BUS_RST_N=0 at edge): state=IDLE, grant=0, last_grant=CHANNELS-1, burst_cnt=0, OUT_VALID=0, OUT_DATA=0, WORD_CNT all 0, BUSY=0, RX_FIFO_READ=0. Reset mid-burst drops the output register contents; words already popped are lost (documented, not recovered).
- RX FIFO semantics: data valid whenever EMPTY=0; READ pops at the same edge; READ must never be asserted while EMPTY=1.
- Output register slot: free = !OUT_VALID | OUT_READY.
- RX_FIFO_READ[g] = (state==STREAM) & (grant==g) & !RX_FIFO_EMPTY[g] & CH_ENABLE[g] & free. Combinational from OUT_READY (single-level path, allowed).
- On pop: OUT_DATA<=RX_FIFO_DATA[grant], OUT_VALID<=1, burst_cnt++, WORD_CNT[grant]++ (saturates at all-ones). Else if OUT_READY: OUT_VALID<=0.
- Throughput: 1 word/cycle within a burst; latency pop->OUT_VALID = 1 cycle.
- FSM IDLE: search channels last_grant+1 .. last_grant+CHANNELS (mod CHANNELS) for first with CH_ENABLE & !EMPTY; if found, grant<=it, burst_cnt<=0, ->STREAM. 1 idle cycle per grant change. None found: stay.
- FSM STREAM -> IDLE (last_grant<=grant) at the edge where any holds: pop with burst_cnt reaching BURST_MAX; granted channel EMPTY with no pop; CH_ENABLE[grant]=0.
- Disable mid-burst: no further pops from that channel; the word already in the output register is still delivered.
- Backpressure: OUT_VALID/OUT_DATA stable while OUT_VALID & !OUT_READY; no pops occur.
- CNT_CLEAR: all counters <=0; has priority over a simultaneous increment (that word not counted).
- CHANNELS=1: arbitration degenerates; burst limit still forces a 1-cycle IDLE gap after BURST_MAX words.

Decomposition:
- Shared package: state encoding (IDLE, STREAM), FIFO word width constant 32, channel-index width function (clog2).
- One sub-module: rr_select (combinational round-robin search: request vector + last_grant -> found, index).

Test Plan:
- Ch0 holds 5 words 0xA0..0xA4, others empty, OUT_READY=1 -> 5 consecutive OUT_VALID cycles with 0xA0..0xA4 in order, WORD_CNT[0]=5, return to IDLE.
- Ch0 and ch2 each hold 40 words, BURST_MAX=16 -> output order ch0x16, ch2x16, ch0x16, ch2x16, ch0x8, ch2x8; one gap cycle between bursts.
- OUT_READY low 3 cycles mid-burst -> OUT_DATA held constant, RX_FIFO_READ=0 for those cycles, no word lost or duplicated.
- CH_ENABLE[1] cleared after 4 of 10 words -> exactly 4 words forwarded (plus at most the one registered), arbiter moves to next requesting channel.
- Drive WORD_CNT[3] to 0xFFFF with CNT_WIDTH=16, add 2 words -> stays 0xFFFF; CNT_CLEAR concurrent with a pop -> counter 0.
- Assert BUS_RST_N=0 during a burst -> next cycle OUT_VALID=0, BUSY=0, counters 0, RX_FIFO_READ=0.

Source files
------------

// File: rtl/fei4_rx_merger_pkg.sv
// Shared types and helpers for the fei4_rx FIFO merger.
package fei4_rx_merger_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int WORD_W = 32;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fei4_rx_merger_rr_select.sv
// Combinational round-robin search: first requester after last, wrapping,
// with last itself checked at the very end.
module fei4_rx_merger_rr_select
  import fei4_rx_merger_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0] cand;

  // Walk offsets from far to near so the nearest requester is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fei4_rx_merger.sv
// Merges up to CHANNELS fei4_rx FWFT FIFOs into one 32-bit ready/valid stream
// with round-robin bursts and saturating per-channel word counters.
module fei4_rx_merger
  import fei4_rx_merger_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int BURST_MAX = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          BUS_CLK,
  input  logic                          BUS_RST_N,
  input  logic [CHANNELS-1:0]           RX_FIFO_EMPTY,
  input  logic [WORD_W*CHANNELS-1:0]    RX_FIFO_DATA,
  output logic [CHANNELS-1:0]           RX_FIFO_READ,
  input  logic [CHANNELS-1:0]           CH_ENABLE,
  input  logic                          CNT_CLEAR,
  output logic [WORD_W-1:0]             OUT_DATA,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [CNT_WIDTH*CHANNELS-1:0] WORD_CNT,
  output logic                          BUSY
);

  localparam int IW = idx_width(CHANNELS);

  state_t            state_reg;
  logic [IW-1:0]     grant_reg;
  logic [IW-1:0]     last_grant_reg;
  logic [7:0]        burst_cnt_reg;
  logic [WORD_W-1:0] out_data_reg;
  logic              out_valid_reg;

  logic [CHANNELS-1:0] req;
  logic                found;
  logic [IW-1:0]       next_grant;
  logic                slot_free;
  logic                pop;
  logic                burst_done;
  logic                stream_end;
  logic [WORD_W-1:0]   ch_data [CHANNELS];

  assign req       = CH_ENABLE & ~RX_FIFO_EMPTY;
  assign slot_free = !out_valid_reg || OUT_READY;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_reg;

    assign ch_data[gi]      = RX_FIFO_DATA[WORD_W*gi +: WORD_W];
    assign RX_FIFO_READ[gi] = (state_reg == STREAM) && (grant_reg == IW'(gi)) &&
                              req[gi] && slot_free;

    // Clear wins over a same-cycle pop; that word is deliberately not counted.
    always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N || CNT_CLEAR)
        cnt_reg <= '0;
      else if (RX_FIFO_READ[gi] && (cnt_reg != '1))
        cnt_reg <= cnt_reg + 1'b1;
    end

    assign WORD_CNT[CNT_WIDTH*gi +: CNT_WIDTH] = cnt_reg;
  end

  fei4_rx_merger_rr_select #(
    .N  (CHANNELS),
    .IW (IW)
  ) u_rr_select (
    .req   (req),
    .last  (last_grant_reg),
    .found (found),
    .idx   (next_grant)
  );

  assign pop        = |RX_FIFO_READ;
  assign burst_done = pop && ((burst_cnt_reg + 8'd1) == 8'(BURST_MAX));
  assign stream_end = burst_done || (!pop && RX_FIFO_EMPTY[grant_reg]) ||
                      !CH_ENABLE[grant_reg];

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IW'(CHANNELS - 1);
      burst_cnt_reg  <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      if (pop) begin
        out_data_reg  <= ch_data[grant_reg];
        out_valid_reg <= 1'b1;
        burst_cnt_reg <= burst_cnt_reg + 8'd1;
      end else if (OUT_READY) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (found) begin
            grant_reg     <= next_grant;
            burst_cnt_reg <= '0;
            state_reg     <= STREAM;
          end
        end
        STREAM: begin
          if (stream_end) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign OUT_DATA  = out_data_reg;
  assign OUT_VALID = out_valid_reg;
  assign BUSY      = (state_reg == STREAM);

endmodule
